// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demultiplexer: each input beat goes to one of two 2-entry channel buffers.
// Optional build macro DEMUX_RR_EN: ignore s and alternate channels with a round-robin pointer.

// Handshake: a beat moves on a rising edge when valid & ready are both high; a producer
// holding valid must keep its data stable until ready, and ready never depends on the
// same-cycle ready of a downstream consumer.

module demux_chan_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             wr_en;
  logic             rd_en;

  // Internal guards keep the buffer safe even if a caller misbehaves.
  assign wr_en = push && (count != 2'd2);
  assign rd_en = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];
  assign level = count;

endmodule

module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             s,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic [1:0]       y0_level,
  output logic [1:0]       y1_level
);

  logic       sel;
  logic [1:0] sel_level;
  logic       accept;
  logic       push0;
  logic       push1;
  logic       pop0;
  logic       pop1;

`ifdef DEMUX_RR_EN
  logic rr_ptr;
  logic unused_s;

  assign unused_s = s;

  // The pointer only moves on an accepted beat, so a full channel holds the turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign sel = rr_ptr;
`else
  assign sel = s;
`endif

  // Ready looks only at registered occupancy: a full channel refuses even if it pops now.
  assign sel_level = sel ? y1_level : y0_level;
  assign i_ready   = (sel_level < 2'd2);
  assign accept    = i_valid && i_ready;
  assign push0     = accept && !sel;
  assign push1     = accept && sel;
  assign pop0      = y0_valid && y0_ready;
  assign pop1      = y1_valid && y1_ready;

  demux_chan_buf #(.WIDTH(WIDTH)) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (i_data),
    .pop       (pop0),
    .valid     (y0_valid),
    .data      (y0_data),
    .level     (y0_level)
  );

  demux_chan_buf #(.WIDTH(WIDTH)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (i_data),
    .pop       (pop1),
    .valid     (y1_valid),
    .data      (y1_data),
    .level     (y1_level)
  );

endmodule

// File: doc/demux1x2_stream.md
Name: demux1x2_stream

Overview:
- 1-to-2 stream demultiplexer: the receiving end of the team's 2:1 select-based mux path.
- A single input word stream with a per-beat select is steered to one of two output channels.
- Each output channel has its own 2-entry buffer, so one stalled consumer does not block beats bound for the other channel once they reach its buffer.
- Sits between a shared datapath and two independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- i_ready  output  1  input beat accepted when i_valid & i_ready at a rising edge.
- i_data  input  WIDTH  input word.
- s  input  1  channel select for the beat: 0 -> channel 0, 1 -> channel 1.
- y0_valid  output  1  channel 0 head valid.
- y0_ready  input  1  channel 0 consumer ready.
- y0_data  output  WIDTH  channel 0 head word.
- y1_valid  output  1  channel 1 head valid.
- y1_ready  input  1  channel 1 consumer ready.
- y1_data  output  WIDTH  channel 1 head word.
- y0_level  output  2  channel 0 occupancy, 0..2.
- y1_level  output  2  channel 1 occupancy, 0..2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both buffers empty; levels 0.
  - y0_valid = y1_valid = 0; y0_data = y1_data = 0.
  - Active pointer (RR mode) = 0.
  - Reset mid-transfer discards all buffered words; no output beat is completed during reset.
- Channel buffers:
  - Per channel, a 2-entry FIFO with read pointer, write pointer and 2-bit count.
  - Pointers wrap 1 -> 0.
- Selected channel:
  - sel = s in default build.
- Ready:
  - i_ready = (level of sel channel < 2).
  - Depends only on registered state and s; no combinational path from y0_ready/y1_ready to i_ready.
  - i_ready is low when the selected channel is full, even if that channel pops in the same cycle (no pass-through when full).
- Write:
  - On i_valid & i_ready, i_data is written at the sel channel's write pointer; that count +1 unless a same-channel pop also occurs.
- Pop:
  - On yN_valid & yN_ready, the head is removed; count -1 unless a same-channel push also occurs.
  - Simultaneous push and pop on one channel with level 1 or 2 before the edge: level unchanged, order preserved.
- Outputs:
  - yN_valid = (levelN != 0).
  - yN_data = entry at read pointer; it holds stable while yN_valid & !yN_ready.
- Latency:
  - A word accepted at edge k appears on an empty channel's output after edge k (visible cycle k+1).
  - Minimum latency 1 cycle; throughput 1 beat/cycle per channel with no bubbles when the consumer is always ready.
- Ordering: FIFO order per channel; no ordering relation between channels.
- Width: levels are 2 bits and never exceed 2; the design must not write when full and must not read when empty.
- i_data and s are ignored when i_valid = 0.

Optional Feature:
- Macro DEMUX_RR_EN.
- Defined:
  - s is ignored.
  - sel = a registered active pointer, reset 0, toggled on each accepted input beat, so accepted beats alternate ch0, ch1, ch0, ...
  - i_ready uses the pointed channel's level.
  - The pointer does not advance while that channel is full, so the input stalls until that channel drains.
- Not defined: sel = s, with no pointer register present.

Test Plan:
- Reset:
  - Stimulus: drive data, then pulse rst_n low asynchronously mid-cycle.
  - Required: y0_valid/y1_valid fall immediately; levels 0; data outputs 0.
- Basic steer:
  - Stimulus: both consumers ready; beats (s=0, 0xA5), (s=1, 0x3C).
  - Required: y0_data = 0xA5 valid one cycle after acceptance; y1_data = 0x3C one cycle after its acceptance.
- Backpressure/full:
  - Stimulus: y0_ready = 0; send s=0 beats 0x11, 0x22, 0x33.
  - Required: first two accepted; y0_level = 2; i_ready = 0 for the third.
  - Required: y1 beats with s=1 still accepted while channel 0 is full.
- Simultaneous push/pop:
  - Stimulus: channel 0 at level 1; push 0x44 while y0_ready = 1.
  - Required: level stays 1; the output sequence is the old head, then 0x44.
- Full with pop same cycle:
  - Stimulus: channel 0 at level 2, y0_ready = 1, s=0 beat valid.
  - Required: i_ready = 0 that cycle; the beat is accepted the next cycle.
- RR mode (DEMUX_RR_EN defined):
  - Stimulus: send 0x01..0x04 with s held at 1.
  - Required: y0 gets 0x01, 0x03; y1 gets 0x02, 0x04.
  - Stimulus: stall y0 until full.
  - Required: input stalls on the ch0 turn; the pointer does not skip to ch1.
